dmem_responder: RTL and testbench

// - Responder (memory side) of the CPU data-memory port: serves mem_wen/mem_addr/mem_wdata requests and returns mem_rdata.
// - Models a multi-cycle SRAM: stalls the requester for a fixed latency, then completes the access.
// - Sits between the RISC-V core's D-port and the testbench / SoC top. Used to bring up the stall-capable core.

---
 rtl/dmem_responder.sv | 147 ++++++++++++++
 tb/tb_dmem_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle SRAM responder for the core's data port; every access stalls the requester LATENCY+1 cycles.
// Define DMEM_WBUF_EN to add a one-entry posted-write buffer in front of the array.
module dmem_responder #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_cen,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        mem_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [31:0]       mem [DEPTH];
  logic              fsm_req, commit, err_q;
  logic              req_wen_p0, req_oor_p0;
  logic [ADDR_W-1:0] req_idx_p0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_idx;
  logic [31:0]       wr_data;
  logic [ADDR_W-1:0] addr_idx;
  logic              addr_oor;
  logic [1:0]        addr_lsb_unused;

  // Any address bit above the word index, or an index past the last word, misses the array.
  function automatic logic range_err(input logic [29-ADDR_W:0] hi, input logic [ADDR_W-1:0] idx);
    return (hi != '0) || (32'(idx) >= 32'(DEPTH));
  endfunction

  assign addr_idx        = mem_addr[ADDR_W+1:2];
  assign addr_oor        = range_err(mem_addr[31:ADDR_W+2], addr_idx);
  assign addr_lsb_unused = mem_addr[1:0];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (fsm_req) begin
          state_nxt = BUSY;
          cnt_nxt   = 4'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          state_nxt = DONE;
          commit    = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request is latched on acceptance so the access completes even if cen drops mid-flight.
  always_ff @(posedge clk) begin
    if (state == IDLE && fsm_req) begin
      req_wen_p0 <= mem_wen;
      req_idx_p0 <= addr_idx;
      req_oor_p0 <= addr_oor;
    end
  end

`ifdef DMEM_WBUF_EN
  logic              wb_valid, wb_accept, wb_drain, wb_oor;
  logic [3:0]        wb_cnt;
  logic [ADDR_W-1:0] wb_idx;
  logic [31:0]       wb_data;

  // Writes bypass the FSM; reads wait in IDLE until the buffer has drained.
  assign fsm_req   = mem_cen & ~mem_wen & ~wb_valid;
  assign wb_accept = mem_cen & mem_wen & ~wb_valid & (state == IDLE);
  assign wb_drain  = wb_valid & (wb_cnt == '0);
  assign mem_stall = mem_cen & (mem_wen ? ~wb_accept : (state != DONE));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_cnt   <= '0;
    end else if (wb_accept) begin
      wb_valid <= 1'b1;
      wb_cnt   <= 4'(LATENCY);
    end else if (wb_drain) begin
      wb_valid <= 1'b0;
    end else if (wb_valid) begin
      wb_cnt <= wb_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (wb_accept) begin
      wb_idx  <= addr_idx;
      wb_oor  <= addr_oor;
      wb_data <= mem_wdata;
    end
  end

  assign wr_en   = wb_drain & ~wb_oor;
  assign wr_idx  = wb_idx;
  assign wr_data = wb_data;
  assign mem_err = err_q | (wb_drain & wb_oor);
`else
  logic [31:0] req_wdata_p0;

  assign fsm_req   = mem_cen;
  assign mem_stall = mem_cen & (state != DONE);

  always_ff @(posedge clk) begin
    if (state == IDLE && fsm_req) req_wdata_p0 <= mem_wdata;
  end

  assign wr_en   = commit & req_wen_p0 & ~req_oor_p0;
  assign wr_idx  = req_idx_p0;
  assign wr_data = req_wdata_p0;
  assign mem_err = err_q;
`endif

  // Commit edge: BUSY->DONE loads rdata for reads; err_q is high exactly in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      err_q     <= 1'b0;
      mem_rdata <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      err_q <= commit & req_oor_p0;
      if (commit && !req_wen_p0) mem_rdata <= req_oor_p0 ? '0 : mem[req_idx_p0];
      if (wr_en) mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: reset checks, vector table, hand-written corner sequences and a randomized run.
module tb_dmem_responder;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_cen = 1'b0;
  logic        mem_wen = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        mem_err;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] model [256];
  logic [31:0] last_rdata;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl [11];

  dmem_responder #(.LATENCY(LAT), .DEPTH(256), .ADDR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_cen   (mem_cen),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_stall (mem_stall),
    .mem_err   (mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp_v);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the completing (stall=0) cycle.
  task automatic do_access(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err, output int stalls,
                           output logic early_err);
    logic done;
    mem_cen   = 1'b1;
    mem_wen   = wen;
    mem_addr  = addr;
    mem_wdata = wdata;
    stalls    = 0;
    early_err = 1'b0;
    done      = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (!mem_stall) done = 1'b1;
      else begin
        stalls++;
        if (mem_err) early_err = 1'b1;
      end
    end
    check("access_completes", {31'b0, done}, 32'd1);
    rdata = mem_rdata;
    err   = mem_err;
    @(posedge clk);
    #1;
    mem_cen = 1'b0;
    mem_wen = 1'b0;
  endtask

  task automatic apply_reset(input int cycles);
    rst_n   = 1'b0;
    mem_cen = 1'b0;
    mem_wen = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) model[i] = '0;
    last_rdata = '0;
  endtask

  function automatic logic addr_bad(input logic [31:0] a);
    return (a >> 10) != 32'd0;
  endfunction

  function automatic int addr_word(input logic [31:0] a);
    return int'((a >> 2) & 32'hFF);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er, ee;
    int          st;

    tbl[0]  = '{1'b1, 32'h0000_0040, 32'h1122_3344, 32'h0000_0000, 1'b0};
    tbl[1]  = '{1'b0, 32'h0000_0040, 32'h0,         32'h1122_3344, 1'b0};
    tbl[2]  = '{1'b0, 32'h0000_0400, 32'h0,         32'h0000_0000, 1'b1};
    tbl[3]  = '{1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    tbl[4]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b0};
    tbl[5]  = '{1'b1, 32'h0000_0043, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
    tbl[6]  = '{1'b0, 32'h0000_0040, 32'h0,         32'hCAFE_F00D, 1'b0};
    tbl[7]  = '{1'b1, 32'h0000_03FC, 32'h1234_5678, 32'hCAFE_F00D, 1'b0};
    tbl[8]  = '{1'b0, 32'h0000_03FD, 32'h0,         32'h1234_5678, 1'b0};
    tbl[9]  = '{1'b0, 32'h8000_0040, 32'h0,         32'h0000_0000, 1'b1};
    tbl[10] = '{1'b0, 32'h0000_0041, 32'h0,         32'hCAFE_F00D, 1'b0};

    // Reset state
    apply_reset(2);
    @(negedge clk);
    check("reset_rdata", mem_rdata, 32'h0);
    check("reset_stall", {31'b0, mem_stall}, 32'h0);
    check("reset_err", {31'b0, mem_err}, 32'h0);
    @(posedge clk);
    #1;

    do_access(1'b0, 32'h10, 32'h0, rd, er, st, ee);
    check("first_read_rdata", rd, 32'h0);
    check("first_read_stalls", 32'(st), 32'(LAT + 1));

`ifndef DMEM_WBUF_EN
    for (int i = 0; i < 11; i++) begin
      do_access(tbl[i].wen, tbl[i].addr, tbl[i].wdata, rd, er, st, ee);
      check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
      check($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, tbl[i].exp_err});
      check($sformatf("vec%0d_stalls", i), 32'(st), 32'(LAT + 1));
      check($sformatf("vec%0d_early_err", i), {31'b0, ee}, 32'h0);
    end
`else
    // Posted write then an immediate read of the same word
    do_access(1'b1, 32'h20, 32'hA5A5_A5A5, rd, er, st, ee);
    check("wbuf_write_stalls", 32'(st), 32'd0);
    do_access(1'b0, 32'h20, 32'h0, rd, er, st, ee);
    check("wbuf_read_stalls", 32'(st), 32'(2 * (LAT + 1)));
    check("wbuf_read_rdata", rd, 32'hA5A5_A5A5);

    // Back-to-back writes: the second waits for the drain
    do_access(1'b1, 32'h24, 32'h0102_0304, rd, er, st, ee);
    check("wbuf_w1_stalls", 32'(st), 32'd0);
    do_access(1'b1, 32'h28, 32'h0A0B_0C0D, rd, er, st, ee);
    check("wbuf_w2_stalls", 32'(st), 32'(LAT + 1));
    do_access(1'b0, 32'h24, 32'h0, rd, er, st, ee);
    check("wbuf_rd1", rd, 32'h0102_0304);
    do_access(1'b0, 32'h28, 32'h0, rd, er, st, ee);
    check("wbuf_rd2", rd, 32'h0A0B_0C0D);

    // Out-of-range posted write: err pulses once, on the drain cycle
    begin
      int err_hits, err_at;
      do_access(1'b1, 32'h400, 32'hFFFF_FFFF, rd, er, st, ee);
      check("wbuf_oor_accept_err", {31'b0, er}, 32'h0);
      err_hits = 0;
      err_at   = -1;
      for (int c = 1; c <= 5; c++) begin
        @(negedge clk);
        if (mem_err) begin
          err_hits++;
          if (err_at < 0) err_at = c;
        end
        @(posedge clk);
        #1;
      end
      check("wbuf_oor_err_cycle", 32'(err_at), 32'(LAT + 1));
      check("wbuf_oor_err_hits", 32'(err_hits), 32'd1);
      do_access(1'b0, 32'h0, 32'h0, rd, er, st, ee);
      check("wbuf_oor_no_alias", rd, 32'h0);
    end
`endif

    // Requester drops cen right after issuing a write; the write still lands
    mem_cen   = 1'b1;
    mem_wen   = 1'b1;
    mem_addr  = 32'h50;
    mem_wdata = 32'h77;
    @(posedge clk);
    #1;
    mem_cen = 1'b0;
    mem_wen = 1'b0;
    @(negedge clk);
    check("cen_drop_stall", {31'b0, mem_stall}, 32'h0);
    idle(4);
    do_access(1'b0, 32'h50, 32'h0, rd, er, st, ee);
    check("cen_drop_rdata", rd, 32'h77);

    // Reset one cycle into a write aborts it
    mem_cen   = 1'b1;
    mem_wen   = 1'b1;
    mem_addr  = 32'h8;
    mem_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    apply_reset(1);
    @(negedge clk);
    check("midreset_stall", {31'b0, mem_stall}, 32'h0);
    check("midreset_rdata", mem_rdata, 32'h0);
    @(posedge clk);
    #1;
    do_access(1'b0, 32'h8, 32'h0, rd, er, st, ee);
    check("midreset_read", rd, 32'h0);
    check("midreset_read_stalls", 32'(st), 32'(LAT + 1));

    // Reset clears stored words
    do_access(1'b1, 32'h4, 32'h5555_AAAA, rd, er, st, ee);
    idle(5);
    do_access(1'b0, 32'h4, 32'h0, rd, er, st, ee);
    check("memclr_before", rd, 32'h5555_AAAA);
    apply_reset(2);
    do_access(1'b0, 32'h4, 32'h0, rd, er, st, ee);
    check("memclr_after", rd, 32'h0);
    last_rdata = rd;

    // Randomized accesses against a word-array reference model
    for (int k = 0; k < 200; k++) begin
      logic        wen, bad;
      logic [31:0] a, d, exp_rd;
      int          w;
      wen = 1'($urandom_range(0, 1));
      w   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
      a   = (32'(w) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = a | (32'd1 << $urandom_range(10, 31));
      d   = $urandom;
      bad = addr_bad(a);
      do_access(wen, a, d, rd, er, st, ee);
      if (wen) begin
        if (!bad) model[addr_word(a)] = d;
        check("rnd_wr_rdata_held", rd, last_rdata);
`ifndef DMEM_WBUF_EN
        check("rnd_wr_err", {31'b0, er}, {31'b0, bad});
`else
        check("rnd_wr_err", {31'b0, er}, 32'h0);
`endif
      end else begin
        exp_rd = bad ? 32'h0 : model[addr_word(a)];
        check("rnd_rd_data", rd, exp_rd);
        check("rnd_rd_err", {31'b0, er}, {31'b0, bad});
        last_rdata = exp_rd;
      end
`ifndef DMEM_WBUF_EN
      check("rnd_stalls", 32'(st), 32'(LAT + 1));
      check("rnd_early_err", {31'b0, ee}, 32'h0);
`endif
      idle(int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
